// File: rtl/lzx_153_rr_ctrl.sv
// Round-robin select/enable sequencer for a dual 4-to-1 mux (74HC153 style).
// Grants one index to one or both banks, waits SETTLE cycles, samples Y1/Y2, then holds for HOLD cycles.
//
// state  | meaning
// IDLE   | enables high, S parked, arbitrating the combined request
// SETTLE | grant driven, counting down before Y1/Y2 are sampled
// HOLD   | grant held after the sample, then released
module lzx_153_rr_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req1,
  input  logic [3:0] req2,
  output logic [1:0] S,
  output logic       E1_n,
  output logic       E2_n,
  input  logic       Y1,
  input  logic       Y2,
  output logic [3:0] gnt1,
  output logic [3:0] gnt2,
  output logic       smp_valid,
  output logic       smp_y1,
  output logic       smp_y2,
  output logic [1:0] smp_idx,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] HOLD_M1   = 8'(HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] s_q, s_d;
  logic       e1_n_q, e1_n_d;
  logic       e2_n_q, e2_n_d;
  logic [3:0] gnt1_q, gnt1_d;
  logic [3:0] gnt2_q, gnt2_d;
  logic       smp_valid_q, smp_valid_d;
  logic       smp_y1_q, smp_y1_d;
  logic       smp_y2_q, smp_y2_d;
  logic [1:0] smp_idx_q, smp_idx_d;
  logic       busy_q, busy_d;

  logic [3:0] req_any;
  logic       arb_hit;
  logic [1:0] arb_idx;
  logic [1:0] arb_cand;

  // Scan offsets from farthest to nearest so the index closest to ptr wins.
  always_comb begin
    req_any  = req1 | req2;
    arb_hit  = 1'b0;
    arb_idx  = ptr_q;
    arb_cand = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      arb_cand = ptr_q + 2'(k);
      if (req_any[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    e1_n_d      = e1_n_q;
    e2_n_d      = e2_n_q;
    gnt1_d      = gnt1_q;
    gnt2_d      = gnt2_q;
    smp_valid_d = 1'b0;
    smp_y1_d    = smp_y1_q;
    smp_y2_d    = smp_y2_q;
    smp_idx_d   = smp_idx_q;

    case (state_q)
      ST_IDLE: begin
        e1_n_d = 1'b1;
        e2_n_d = 1'b1;
        gnt1_d = 4'b0000;
        gnt2_d = 4'b0000;
        if (arb_hit) begin
          // Requests are snapshotted here; later drops do not revoke the grant.
          s_d     = arb_idx;
          e1_n_d  = ~req1[arb_idx];
          e2_n_d  = ~req2[arb_idx];
          gnt1_d  = {3'b000, req1[arb_idx]} << arb_idx;
          gnt2_d  = {3'b000, req2[arb_idx]} << arb_idx;
          cnt_d   = SETTLE_M1;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          smp_y1_d    = Y1 & ~e1_n_q;
          smp_y2_d    = Y2 & ~e2_n_q;
          smp_idx_d   = s_q;
          smp_valid_d = 1'b1;
          cnt_d       = HOLD_M1;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          e1_n_d  = 1'b1;
          e2_n_d  = 1'b1;
          gnt1_d  = 4'b0000;
          gnt2_d  = 4'b0000;
          ptr_d   = s_q + 2'd1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        e1_n_d  = 1'b1;
        e2_n_d  = 1'b1;
        gnt1_d  = 4'b0000;
        gnt2_d  = 4'b0000;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= 8'd0;
      s_q         <= 2'd0;
      e1_n_q      <= 1'b1;
      e2_n_q      <= 1'b1;
      gnt1_q      <= 4'b0000;
      gnt2_q      <= 4'b0000;
      smp_valid_q <= 1'b0;
      smp_y1_q    <= 1'b0;
      smp_y2_q    <= 1'b0;
      smp_idx_q   <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      e1_n_q      <= e1_n_d;
      e2_n_q      <= e2_n_d;
      gnt1_q      <= gnt1_d;
      gnt2_q      <= gnt2_d;
      smp_valid_q <= smp_valid_d;
      smp_y1_q    <= smp_y1_d;
      smp_y2_q    <= smp_y2_d;
      smp_idx_q   <= smp_idx_d;
      busy_q      <= busy_d;
    end
  end

  assign S         = s_q;
  assign E1_n      = e1_n_q;
  assign E2_n      = e2_n_q;
  assign gnt1      = gnt1_q;
  assign gnt2      = gnt2_q;
  assign smp_valid = smp_valid_q;
  assign smp_y1    = smp_y1_q;
  assign smp_y2    = smp_y2_q;
  assign smp_idx   = smp_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lzx_153_rr_ctrl.sv
// Bench for lzx_153_rr_ctrl: directed requests against a behavioural 74HC153 model,
// expected samples queued by the stimulus and checked by a separate monitor.
module tb_lzx_153_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req1, req2;
  logic [1:0] s;
  logic       e1_n, e2_n;
  logic       y1, y2;
  logic [3:0] gnt1, gnt2;
  logic       smp_valid, smp_y1, smp_y2;
  logic [1:0] smp_idx;
  logic       busy;

  logic [3:0] d1 = 4'b0000;
  logic [3:0] d2 = 4'b0000;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] idx;
    logic       y1;
    logic       y2;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mux: output low while its bank is disabled.
  assign y1 = ~e1_n & d1[s];
  assign y2 = ~e2_n & d2[s];

  lzx_153_rr_ctrl #(.SETTLE(2), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2),
    .S(s), .E1_n(e1_n), .E2_n(e2_n), .Y1(y1), .Y2(y2),
    .gnt1(gnt1), .gnt2(gnt2), .smp_valid(smp_valid),
    .smp_y1(smp_y1), .smp_y2(smp_y2), .smp_idx(smp_idx), .busy(busy)
  );

  always @(negedge clk) begin
    if (smp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got idx=%0d y1=%0b y2=%0b at cycle %0d, none expected",
                 smp_idx, smp_y1, smp_y2, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (smp_idx !== e.idx || smp_y1 !== e.y1 || smp_y2 !== e.y2 || cyc != e.cyc) begin
          errors++;
          $display("FAIL sample: got idx=%0d y1=%0b y2=%0b cycle=%0d, expected idx=%0d y1=%0b y2=%0b cycle=%0d",
                   smp_idx, smp_y1, smp_y2, cyc, e.idx, e.y1, e.y2, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic py1, input logic py2, input int at);
    exp_t e;
    e.idx = idx;
    e.y1  = py1;
    e.y2  = py2;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_e1_n"}, 8'(e1_n), 8'h1);
    chk({tag, "_e2_n"}, 8'(e2_n), 8'h1);
    chk({tag, "_s"}, 8'(s), 8'h0);
    chk({tag, "_gnt1"}, 8'(gnt1), 8'h0);
    chk({tag, "_gnt2"}, 8'(gnt2), 8'h0);
    chk({tag, "_smp_valid"}, 8'(smp_valid), 8'h0);
    chk({tag, "_busy"}, 8'(busy), 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst  = 1'b1;
    req1 = 4'hF;
    req2 = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    // Single request at index 0; D1[0]=0 so the sample is 0.
    rst  = 1'b0;
    req1 = 4'b0001;
    d1   = 4'b1110;
    k    = cyc + 1;
    push(2'd0, 1'b0, 1'b0, k + 2);
    @(negedge clk);
    chk("single_s", 8'(s), 8'h0);
    chk("single_e1_n", 8'(e1_n), 8'h0);
    chk("single_e2_n", 8'(e2_n), 8'h1);
    chk("single_gnt1", 8'(gnt1), 8'h1);
    chk("single_gnt2", 8'(gnt2), 8'h0);
    chk("single_busy", 8'(busy), 8'h1);
    req1 = 4'b0000;
    wait_to(k + 5);
    chk("single_e1_n_held", 8'(e1_n), 8'h0);
    wait_to(k + 6);
    chk("single_e1_n_release", 8'(e1_n), 8'h1);
    chk("single_gnt1_release", 8'(gnt1), 8'h0);
    chk("single_busy_release", 8'(busy), 8'h0);

    // Round robin from ptr=0 with all four bank-1 requests held.
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    req1 = 4'b1111;
    d1   = 4'b1010;
    k    = cyc + 1;
    push(2'd0, 1'b0, 1'b0, k + 2);
    push(2'd1, 1'b1, 1'b0, k + 9);
    push(2'd2, 1'b0, 1'b0, k + 16);
    push(2'd3, 1'b1, 1'b0, k + 23);
    push(2'd0, 1'b0, 1'b0, k + 30);
    wait_to(k + 6);
    chk("rr_gap_e1_n", 8'(e1_n), 8'h1);
    wait_to(k + 7);
    chk("rr_second_s", 8'(s), 8'h1);
    chk("rr_second_gnt1", 8'(gnt1), 8'h2);
    wait_to(k + 28);
    req1 = 4'b0000;
    wait_to(k + 34);
    chk("rr_end_e1_n", 8'(e1_n), 8'h1);
    chk("rr_end_busy", 8'(busy), 8'h0);

    // Both banks request index 2 (ptr=1).
    req1 = 4'b0100;
    req2 = 4'b0100;
    d1   = 4'b0100;
    d2   = 4'b0100;
    k    = cyc + 1;
    push(2'd2, 1'b1, 1'b1, k + 2);
    @(negedge clk);
    chk("shared_s", 8'(s), 8'h2);
    chk("shared_e1_n", 8'(e1_n), 8'h0);
    chk("shared_e2_n", 8'(e2_n), 8'h0);
    chk("shared_gnt1", 8'(gnt1), 8'h4);
    chk("shared_gnt2", 8'(gnt2), 8'h4);
    req1 = 4'b0000;
    req2 = 4'b0000;
    wait_to(k + 6);

    // Split indices from ptr=3: bank 2 at index 3 first, then bank 1 at index 0.
    req1 = 4'b0001;
    req2 = 4'b1000;
    d1   = 4'b0001;
    d2   = 4'b1000;
    k    = cyc + 1;
    push(2'd3, 1'b0, 1'b1, k + 2);
    push(2'd0, 1'b1, 1'b0, k + 9);
    @(negedge clk);
    chk("split_a_s", 8'(s), 8'h3);
    chk("split_a_e1_n", 8'(e1_n), 8'h1);
    chk("split_a_e2_n", 8'(e2_n), 8'h0);
    chk("split_a_gnt1", 8'(gnt1), 8'h0);
    chk("split_a_gnt2", 8'(gnt2), 8'h8);
    wait_to(k + 7);
    chk("split_b_s", 8'(s), 8'h0);
    chk("split_b_e1_n", 8'(e1_n), 8'h0);
    chk("split_b_e2_n", 8'(e2_n), 8'h1);
    chk("split_b_gnt1", 8'(gnt1), 8'h1);
    chk("split_b_gnt2", 8'(gnt2), 8'h0);
    req1 = 4'b0000;
    req2 = 4'b0000;
    wait_to(k + 13);

    // Reset mid-SETTLE: grant aborted, no sample.
    req1 = 4'b0010;
    d1   = 4'b0010;
    k    = cyc + 1;
    @(negedge clk);
    chk("abort_settle_s", 8'(s), 8'h1);
    chk("abort_settle_e1_n", 8'(e1_n), 8'h0);
    rst  = 1'b1;
    req1 = 4'b0000;
    @(negedge clk);
    chk_reset_vals("abort_settle");
    rst = 1'b0;

    // Reset mid-HOLD: sample already taken, nothing further afterwards.
    req1 = 4'b0010;
    k    = cyc + 1;
    push(2'd1, 1'b1, 1'b0, k + 2);
    wait_to(k + 3);
    chk("abort_hold_busy", 8'(busy), 8'h1);
    chk("abort_hold_e1_n", 8'(e1_n), 8'h0);
    rst  = 1'b1;
    req1 = 4'b0000;
    @(negedge clk);
    chk_reset_vals("abort_hold");
    rst = 1'b0;
    wait_to(k + 12);

    // Request dropped during SETTLE keeps the grant and still samples.
    req2 = 4'b0100;
    d2   = 4'b0100;
    k    = cyc + 1;
    push(2'd2, 1'b0, 1'b1, k + 2);
    @(negedge clk);
    chk("drop_e2_n", 8'(e2_n), 8'h0);
    chk("drop_e1_n", 8'(e1_n), 8'h1);
    chk("drop_gnt2", 8'(gnt2), 8'h4);
    req2 = 4'b0000;
    @(negedge clk);
    chk("drop_e2_n_kept", 8'(e2_n), 8'h0);
    chk("drop_gnt2_kept", 8'(gnt2), 8'h4);
    wait_to(k + 8);
    chk("drop_released_e2_n", 8'(e2_n), 8'h1);

    chk("scoreboard_drained", 8'(sb.size()), 8'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
